// File: rtl/sd_pkg.sv
// Shared constants for the SD block-buffer write path.
// Holds the packer FSM encoding, the block geometry and the byte-lane placement helper.
package sd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SD_BLOCK_BYTES = 512;
  localparam int SD_BUF_WORDS   = SD_BLOCK_BYTES / 4;

  // Byte position inside the 32-bit word for a given arrival lane.
  function automatic logic [1:0] lane_pos(input logic [1:0] lane, input logic little);
    return little ? lane : (2'd3 - lane);
  endfunction

endpackage

// File: rtl/sd_byte_lane_asm.sv
// Four-lane byte assembler. It collects bytes into a 32-bit word and
// flags the byte that completes the word, with the completed word presented alongside it.
module sd_byte_lane_asm
  import sd_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_lane;
  logic [31:0] r_asm;
  logic [1:0]  w_pos;
  logic [31:0] w_word;

  assign w_pos = lane_pos(r_lane, LITTLE_ENDIAN);

  // The completing byte is merged combinationally so the word is whole in the same cycle.
  always_comb begin
    w_word = r_asm;
    w_word[{w_pos, 3'b000} +: 8] = i_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane <= 2'd0;
      r_asm  <= 32'd0;
    end else if (i_clr) begin
      r_lane <= 2'd0;
      r_asm  <= 32'd0;
    end else if (i_byte_en) begin
      r_lane <= r_lane + 2'd1;
      r_asm  <= w_word;
    end
  end

  assign o_word_valid = i_byte_en && (r_lane == 2'd3);
  assign o_word       = w_word;

endmodule

// File: rtl/sd_word_packer.sv
// Packs the SD SPI byte stream into 32-bit block-buffer writes and
// tracks the word address, the block count, block completion and bytes that arrive after the block is full.
//
// state | meaning
// IDLE  | no block open, bytes ignored
// FILL  | collecting bytes, one buffer write per 4 bytes
// DONE  | block complete, further bytes set the overflow flag
module sd_word_packer
  import sd_pkg::*;
#(
  parameter int WORDS         = SD_BUF_WORDS,
  parameter int ADDR_W        = 7,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic              iCLK,
  input  logic              Reset,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iByteValid,
  input  logic [7:0]        iByte,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [31:0]       oWrData,
  output logic              oBusy,
  output logic              oBlockDone,
  output logic [ADDR_W:0]   oWordCount,
  output logic              oOverflow
);

  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W:0]   L_WORDS = (ADDR_W + 1)'(WORDS);

  logic [1:0]        r_state;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_block_done;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_word_idx;
  logic              r_overflow;

  logic              w_accept;
  logic              w_clr;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic              w_last;

  // iStart and iAbort both win over a byte arriving in the same cycle.
  assign w_accept = (r_state == ST_FILL) && iByteValid && !iStart && !iAbort;
  assign w_clr    = iStart || iAbort;
  assign w_last   = w_word_valid && (r_word_idx == L_LAST);

  sd_byte_lane_asm #(
    .LITTLE_ENDIAN (LITTLE_ENDIAN != 0)
  ) u_lane_asm (
    .i_clk        (iCLK),
    .i_rst_n      (Reset),
    .i_clr        (w_clr),
    .i_byte_en    (w_accept),
    .i_byte       (iByte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 32'd0;
      r_block_done <= 1'b0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_en      <= w_word_valid;
      r_block_done <= w_last;

      if (w_word_valid) begin
        r_wr_data  <= w_word;
        r_wr_addr  <= r_word_idx;
        r_word_idx <= w_last ? '0 : (r_word_idx + 1'b1);
        if (r_count < L_WORDS) begin
          r_count <= r_count + 1'b1;
        end
      end

      if (iStart) begin
        r_state    <= ST_FILL;
        r_word_idx <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (iAbort) begin
        r_state <= ST_IDLE;
      end else if (w_last) begin
        r_state <= ST_DONE;
      end else if ((r_state == ST_DONE) && iByteValid) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign oWrEn      = r_wr_en;
  assign oWrAddr    = r_wr_addr;
  assign oWrData    = r_wr_data;
  assign oBusy      = (r_state == ST_FILL);
  assign oBlockDone = r_block_done;
  assign oWordCount = r_count;
  assign oOverflow  = r_overflow;

endmodule

// File: tb/tb_sd_word_packer.sv
// Directed bench for sd_word_packer: little- and big-endian instances share stimulus,
// writes are logged at the falling edge and checked against hand-computed values.
module tb_sd_word_packer;

  logic        iCLK = 1'b0;
  logic        Reset = 1'b0;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic        iByteValid = 1'b0;
  logic [7:0]  iByte = 8'd0;

  logic        oWrEn, oBusy, oBlockDone, oOverflow;
  logic [6:0]  oWrAddr;
  logic [31:0] oWrData;
  logic [7:0]  oWordCount;

  logic        b_wr_en, b_busy, b_block_done, b_overflow;
  logic [6:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [7:0]  b_word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          bd_cnt = 0;
  int          bd_at  = -1;

  always #5 iCLK = ~iCLK;

  sd_word_packer #(.WORDS(128), .ADDR_W(7), .LITTLE_ENDIAN(1)) u_dut_le (
    .iCLK(iCLK), .Reset(Reset), .iStart(iStart), .iAbort(iAbort),
    .iByteValid(iByteValid), .iByte(iByte),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData), .oBusy(oBusy),
    .oBlockDone(oBlockDone), .oWordCount(oWordCount), .oOverflow(oOverflow)
  );

  sd_word_packer #(.WORDS(128), .ADDR_W(7), .LITTLE_ENDIAN(0)) u_dut_be (
    .iCLK(iCLK), .Reset(Reset), .iStart(iStart), .iAbort(iAbort),
    .iByteValid(iByteValid), .iByte(iByte),
    .oWrEn(b_wr_en), .oWrAddr(b_wr_addr), .oWrData(b_wr_data), .oBusy(b_busy),
    .oBlockDone(b_block_done), .oWordCount(b_word_count), .oOverflow(b_overflow)
  );

  always @(negedge iCLK) begin
    if (oWrEn) begin
      log_addr.push_back(oWrAddr);
      log_data.push_back(oWrData);
    end
    if (oBlockDone) begin
      bd_cnt++;
      bd_at = log_addr.size();
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    iByteValid = 1'b1;
    iByte      = b;
    @(posedge iCLK);
    #1;
    iByteValid = 1'b0;
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
  endtask

  task automatic pulse_abort();
    iAbort = 1'b1;
    @(posedge iCLK);
    #1;
    iAbort = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_wren",  32'(oWrEn), 32'd0);
    chk("rst_addr",  32'(oWrAddr), 32'd0);
    chk("rst_data",  oWrData, 32'd0);
    chk("rst_count", 32'(oWordCount), 32'd0);
    chk("rst_flags", {28'd0, oBusy, oBlockDone, oOverflow, b_busy}, 32'd0);
    @(posedge iCLK);
    #1 Reset = 1'b1;
    idle_cycles(2);

    // Four bytes on consecutive cycles: write is visible one cycle after the last.
    pulse_start();
    chk("busy_fill", 32'(oBusy), 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("le_wren",  32'(oWrEn), 32'd1);
    chk("le_addr",  32'(oWrAddr), 32'd0);
    chk("le_data",  oWrData, 32'h44332211);
    chk("le_count", 32'(oWordCount), 32'd1);
    chk("be_data",  b_wr_data, 32'h11223344);
    chk("be_wren",  32'(b_wr_en), 32'd1);

    // Reset mid-fill after 6 bytes.
    send_byte(8'h55);
    send_byte(8'h66);
    #2 Reset = 1'b0;
    #1;
    chk("mrst_data",  oWrData, 32'd0);
    chk("mrst_count", 32'(oWordCount), 32'd0);
    chk("mrst_busy",  32'(oBusy), 32'd0);
    chk("mrst_wren",  32'(oWrEn), 32'd0);
    @(posedge iCLK);
    #1 Reset = 1'b1;
    idle_cycles(1);

    // Full 512-byte block.
    log_addr.delete();
    log_data.delete();
    bd_cnt = 0;
    pulse_start();
    for (int i = 0; i < 512; i++) send_byte(8'(i));
    chk("blk_wren",  32'(oWrEn), 32'd1);
    chk("blk_done",  32'(oBlockDone), 32'd1);
    chk("blk_last",  oWrData, 32'hFFFEFDFC);
    chk("blk_count", 32'(oWordCount), 32'd128);
    chk("blk_busy",  32'(oBusy), 32'd0);
    idle_cycles(3);
    chk("blk_nwr",   32'(log_addr.size()), 32'd128);
    chk("blk_bdcnt", 32'(bd_cnt), 32'd1);
    chk("blk_bdat",  32'(bd_at), 32'd128);
    if (log_addr.size() == 128) begin
      for (int i = 0; i < 128; i++) chk($sformatf("blk_addr%0d", i), 32'(log_addr[i]), 32'(i));
      chk("blk_w0",   log_data[0], 32'h03020100);
      chk("blk_w127", log_data[127], 32'hFFFEFDFC);
    end
    chk("blk_count_hold", 32'(oWordCount), 32'd128);

    // Overflow in DONE, then restart.
    send_byte(8'hAB);
    idle_cycles(2);
    chk("ovf_set",   32'(oOverflow), 32'd1);
    chk("ovf_nowr",  32'(log_addr.size()), 32'd128);
    chk("ovf_count", 32'(oWordCount), 32'd128);
    pulse_start();
    chk("ovf_clr",   32'(oOverflow), 32'd0);
    chk("rst_cnt0",  32'(oWordCount), 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    chk("re_wren", 32'(oWrEn), 32'd1);
    chk("re_addr", 32'(oWrAddr), 32'd0);
    chk("re_data", oWrData, 32'h04030201);

    // Abort after 6 bytes.
    idle_cycles(1);
    log_addr.delete();
    log_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h20 + i));
    pulse_abort();
    idle_cycles(2);
    chk("abt_nwr",   32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) chk("abt_addr", 32'(log_addr[0]), 32'd0);
    chk("abt_busy",  32'(oBusy), 32'd0);
    chk("abt_count", 32'(oWordCount), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'hC0);
    idle_cycles(2);
    chk("idle_nwr", 32'(log_addr.size()), 32'd1);
    chk("idle_ovf", 32'(oOverflow), 32'd0);

    // iStart with a byte in the same cycle: that byte is dropped.
    iStart = 1'b1;
    iByteValid = 1'b1;
    iByte = 8'hAA;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    iByteValid = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    chk("drop_nowr", 32'(oWrEn), 32'd0);
    send_byte(8'h04);
    chk("drop_wren", 32'(oWrEn), 32'd1);
    chk("drop_addr", 32'(oWrAddr), 32'd0);
    chk("drop_data", oWrData, 32'h04030201);
    chk("drop_be",   b_wr_data, 32'h01020304);

    idle_cycles(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
